bin2bcd_seq: RTL and testbench

Sequential double-dabble binary-to-BCD converter. It sits between the value source (counter/LFSR mode mux) and the 7-segment LED controller. It replaces a combinational converter with a registered, handshaked one-bit-per-cycle engine. The digit outputs are held stable between conversions, so the display multiplexer never sees intermediate values.

---
 rtl/bin2bcd_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Handshake/result bundle between a value source and the bin2bcd_seq converter.
interface bin2bcd_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, blank
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Result, blank mask, busy and done are all register outputs; bcd/blank are held
// between conversions. Optional leading-zero blanking: define BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  bin2bcd_if.slave   bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      sreg_q, sreg_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d, scr_adj;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q, done_q;

  // Add-3 correction on every scratch digit that is 5 or more.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sreg_d  = bus.bin;
          scr_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        // Digits that overflow the top of scr are dropped (truncation).
        {scr_d, sreg_d} = {scr_adj, sreg_q} << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = scr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_q == StDone);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Blank digit i (i >= 1) when it and every higher digit are zero; ones digit always shown.
  always_comb begin
    logic upper_zero;
    blank_d    = blank_q;
    upper_zero = 1'b1;
    if (state_q == StDone) begin
      blank_d = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        upper_zero = upper_zero & (scr_q[4*i +: 4] == 4'd0);
        blank_d[i] = upper_zero;
      end
    end
  end

  // Blank mask register; resets to "show only the ones digit".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blank_q <= ~DIGITS'(1);
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values,
// compared against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  bin2bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int rem;
    rem = v % (10 ** DIGITS);
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] b;
    int rem;
    b   = '0;
    rem = v % (10 ** DIGITS);
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < int'(DIGITS); i++) b[i] = (rem < 10 ** i);
`endif
    return b;
  endfunction

  function automatic logic [DIGITS-1:0] reset_blank();
    logic [DIGITS-1:0] b;
    b = '0;
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < int'(DIGITS); i++) b[i] = 1'b1;
`endif
    return b;
  endfunction

  // One conversion; optionally checks that bcd holds a previous value until done.
  task automatic run_conv(input int v, input bit chk_hold, input logic [4*DIGITS-1:0] held);
    int c;
    bit busy_ok, hold_ok;
    busy_ok   = 1'b1;
    hold_ok   = 1'b1;
    bus.start = 1'b1;
    bus.bin   = WIDTH'(v);
    @(negedge clk_i);
    bus.start = 1'b0;
    bus.bin   = WIDTH'($urandom);
    c = 0;
    while (!bus.done && c < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (chk_hold && bus.bcd !== held) hold_ok = 1'b0;
      @(negedge clk_i);
      c++;
    end
    check($sformatf("latency[%0d]", v), c, WIDTH + 1);
    check($sformatf("busy_during[%0d]", v), 32'(busy_ok), 1);
    if (chk_hold) check($sformatf("bcd_hold[%0d]", v), 32'(hold_ok), 1);
    check($sformatf("bcd[%0d]", v), bus.bcd, ref_bcd(v));
    check($sformatf("blank[%0d]", v), bus.blank, ref_blank(v));
    check($sformatf("busy_at_done[%0d]", v), bus.busy, 0);
    @(negedge clk_i);
    check($sformatf("done_width[%0d]", v), bus.done, 0);
  endtask

  initial begin
    int pulses, first_c, prev_c;
    logic [4*DIGITS-1:0] first_bcd;
    bit prev_done, width_ok, gap_ok, val_ok;

    bus.start = 1'b0;
    bus.bin   = '0;

    // Reset state
    #2 rst_ni = 1'b0;
    #10;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd, 0);
    check("rst_blank", bus.blank, reset_blank());
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed values, including hold of the previous result
    run_conv(255, 1'b0, '0);
    run_conv(0, 1'b0, '0);
    run_conv(100, 1'b0, '0);
    run_conv(9, 1'b1, 12'h100);

    // Second start during a conversion is ignored
    bus.start = 1'b1;
    bus.bin   = WIDTH'(37);
    @(negedge clk_i);
    bus.start = 1'b0;
    repeat (3) @(negedge clk_i);
    bus.start = 1'b1;
    bus.bin   = WIDTH'(200);
    @(negedge clk_i);
    bus.start = 1'b0;
    pulses    = 0;
    first_c   = -1;
    first_bcd = '0;
    for (int c = 4; c < 30; c++) begin
      if (bus.done) begin
        pulses++;
        if (first_c < 0) begin
          first_c   = c;
          first_bcd = bus.bcd;
        end
      end
      @(negedge clk_i);
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_latency", first_c, WIDTH + 1);
    check("ignore_bcd", first_bcd, ref_bcd(37));

    // Reset in the middle of a conversion
    bus.start = 1'b1;
    bus.bin   = WIDTH'(128);
    @(negedge clk_i);
    bus.start = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bcd", bus.bcd, 0);
    check("abort_blank", bus.blank, reset_blank());
    @(negedge clk_i);
    rst_ni = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (bus.done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_conv(128, 1'b0, '0);

    // start held high: one result every WIDTH+2 cycles
    bus.start = 1'b1;
    bus.bin   = WIDTH'(5);
    @(negedge clk_i);
    pulses    = 0;
    first_c   = -1;
    prev_c    = -1;
    prev_done = 1'b0;
    width_ok  = 1'b1;
    gap_ok    = 1'b1;
    val_ok    = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (bus.done) begin
        if (prev_done) width_ok = 1'b0;
        if (bus.bcd !== ref_bcd(5)) val_ok = 1'b0;
        if (first_c < 0) first_c = c;
        if (prev_c >= 0 && c - prev_c != int'(WIDTH) + 2) gap_ok = 1'b0;
        prev_c = c;
        pulses++;
      end
      if (bus.done && bus.busy) width_ok = 1'b0;
      prev_done = bus.done;
      @(negedge clk_i);
    end
    bus.start = 1'b0;
    check("stream_first", first_c, WIDTH + 1);
    check("stream_pulses", pulses, 4);
    check("stream_width", 32'(width_ok), 1);
    check("stream_gap", 32'(gap_ok), 1);
    check("stream_bcd", 32'(val_ok), 1);
    repeat (15) @(negedge clk_i);

    // Random values
    for (int k = 0; k < 20; k++) begin
      run_conv(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
